// File: rtl/ps_pkg.sv
// ps_pkg: shared state encodings and default link width for the LSU serial link
package ps_pkg;
  localparam int LINK_WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/ps_if.sv
// ps_if: load handshake and serial output bundle of the ps shifter
interface ps_if import ps_pkg::*; #(parameter int WIDTH = LINK_WIDTH);
  logic [WIDTH-1:0] d;
  logic load_valid, load_ready, flush, q, en, busy, done;
  modport master(output d, load_valid, flush, input load_ready, q, en, busy, done);
  modport slave(input d, load_valid, flush, output load_ready, q, en, busy, done);
endinterface

// File: rtl/ps_tick.sv
// ps_tick: bit-period counter producing a registered last-cycle-of-period tick
module ps_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic en_i,
  input  logic clr_i,
  output logic last_clk_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d, nxt;
  logic last_q, last_d;
  // next count and whether the coming cycle closes a bit period
  always_comb begin
    nxt = cnt_q == LAST ? '0 : cnt_q + CW'(1);
    cnt_d = clr_i || start_i ? '0 : en_i ? nxt : cnt_q;
    last_d = clr_i ? 1'b0 : start_i ? (LAST == '0) : en_i ? (nxt == LAST) : last_q;
  end
  // counter and tick registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  assign last_clk_o = last_q;
endmodule

// File: rtl/ps.sv
// ps: parallel-to-serial shifter with valid/ready load, per-bit strobe, done pulse and flush
module ps import ps_pkg::*; #(
  parameter int WIDTH = LINK_WIDTH,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst_n,
  ps_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sh;
  logic [BW-1:0] bit_q, bit_d;
  logic q_q, q_d, done_q, done_d;
  logic accept, start, run, clr, last;
  assign sh = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
  assign bus.load_ready = state_q == IDLE || state_q == DONE;
  assign accept = bus.load_valid && bus.load_ready && !bus.flush;
  assign bus.q = q_q;
  assign bus.busy = state_q == SHIFT;
  assign bus.done = done_q;
  // FSM next state, shift register, bit counter and tick control; flush wins over everything
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_d = bit_q;
    q_d = q_q;
    done_d = 1'b0;
    start = 1'b0;
    run = 1'b0;
    clr = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      sr_d = '0;
      bit_d = '0;
      q_d = 1'b0;
      clr = 1'b1;
    end else if (accept) begin
      state_d = SHIFT;
      sr_d = bus.d;
      bit_d = BW'(WIDTH - 1);
      q_d = MSB_FIRST ? bus.d[WIDTH-1] : bus.d[0];
      start = 1'b1;
    end else if (state_q == SHIFT) begin
      run = 1'b1;
      if (last && bit_q == '0) begin
        state_d = DONE;
        done_d = 1'b1;
        q_d = 1'b0;
        clr = 1'b1;
      end else if (last) begin
        sr_d = sh;
        bit_d = bit_q - BW'(1);
        q_d = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      q_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      q_q <= q_d;
      done_q <= done_d;
    end
  ps_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .en_i(run),
    .clr_i(clr),
    .last_clk_o(last)
  );
  assign bus.en = last;
endmodule
